// File: rtl/load_scoreboard_pkg.sv
// rtl/load_scoreboard_pkg.sv - shared register-index constants for the load scoreboard
package load_scoreboard_pkg;

    // Register index width and the hardwired-zero register.
    localparam int              REG_W    = 5;
    localparam int              REG_NUM  = 1 << REG_W;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // True when idx names a real, trackable register (not x0, below nregs).
    function automatic logic reg_tracked(input logic [REG_W-1:0] idx, input int nregs);
        return (idx != REG_ZERO) && (int'(idx) < nregs);
    endfunction

endpackage

// File: rtl/scoreboard_counter.sv
// rtl/scoreboard_counter.sv - clipped up/down in-flight load counter for one register
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   inc             +1 this cycle (load issued to this register)
//   dec_a, dec_b    -1 each this cycle (load completed / load killed)
//   count           current count
//   nonzero         count != 0
//   is_max          count == 2^CNT_W-1
module scoreboard_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec_a,
    input  logic             dec_b,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             is_max
);

    localparam logic [CNT_W:0] MAX_W = (CNT_W+1)'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   up, down, diff;

    // Net change is computed one bit wider so +1 on a full counter and
    // -1 on an empty one are both visible before clipping.
    always_comb begin
        up    = {1'b0, cnt_q} + (CNT_W+1)'(inc);
        down  = (CNT_W+1)'(dec_a) + (CNT_W+1)'(dec_b);
        diff  = up - down;
        cnt_d = cnt_q;
        if (up < down) begin
            // Decrement of an empty counter: protocol error, hold at zero.
            cnt_d = '0;
        end else if (diff > MAX_W) begin
            cnt_d = MAX_W[CNT_W-1:0];
        end else begin
            cnt_d = diff[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count   = cnt_q;
    assign nonzero = (cnt_q != '0);
    assign is_max  = (cnt_q == MAX_W[CNT_W-1:0]);

endmodule

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - decode stall generator tracking in-flight loads per register
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   de_valid, de_is_load, de_rd   decode instruction, load flag, destination
//   de_rs1/de_rs2 (+ _used)       decode sources and whether they are read
//   ld_done, ld_done_rd           load result available in MEM this cycle
//   kill, kill_rd                 in-flight load squashed this cycle
//   de_stall                      hold decode
//   de_fire                       decode instruction issues (de_valid & ~de_stall)
//   stall_cycles, sat_stalls      only with LOAD_SCOREBOARD_STATS_EN defined
//
// Optional feature macro: LOAD_SCOREBOARD_STATS_EN
module load_scoreboard
    import load_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             de_valid,
    input  logic             de_is_load,
    input  logic [REG_W-1:0] de_rd,
    input  logic [REG_W-1:0] de_rs1,
    input  logic [REG_W-1:0] de_rs2,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic             ld_done,
    input  logic [REG_W-1:0] ld_done_rd,
    input  logic             kill,
    input  logic [REG_W-1:0] kill_rd,
    output logic             de_stall,
    output logic             de_fire
`ifdef LOAD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [15:0]      sat_stalls
`endif
);

    logic [CNT_W-1:0] cnt_arr [REG_NUM];
    logic [REG_NUM-1:0] nz_vec;
    logic [REG_NUM-1:0] max_vec;

    logic inc_en, done_en, kill_en;
    logic rs1_haz, rs2_haz, sat_haz;

    // Counter events; x0 and untracked indices never generate events.
    assign inc_en  = de_fire && de_is_load && reg_tracked(de_rd, NREGS);
    assign done_en = ld_done && reg_tracked(ld_done_rd, NREGS);
    assign kill_en = kill && reg_tracked(kill_rd, NREGS);

    for (genvar r = 0; r < REG_NUM; r++) begin : g_reg
        if (r == 0 || r >= NREGS) begin : g_none
            assign cnt_arr[r] = '0;
            assign nz_vec[r]  = 1'b0;
            assign max_vec[r] = 1'b0;
        end else begin : g_cnt
            scoreboard_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk     (clk),
                .reset   (reset),
                .inc     (inc_en  && (de_rd      == REG_W'(r))),
                .dec_a   (done_en && (ld_done_rd == REG_W'(r))),
                .dec_b   (kill_en && (kill_rd    == REG_W'(r))),
                .count   (cnt_arr[r]),
                .nonzero (nz_vec[r]),
                .is_max  (max_vec[r])
            );
        end
    end

    // A sole outstanding load completing this cycle is forwarded from MEM,
    // so it does not hold decode; that is what makes release zero-latency.
    always_comb begin
        rs1_haz = de_rs1_used && (de_rs1 != REG_ZERO) && nz_vec[de_rs1]
                  && !((cnt_arr[de_rs1] == CNT_W'(1)) && ld_done && (ld_done_rd == de_rs1));
        rs2_haz = de_rs2_used && (de_rs2 != REG_ZERO) && nz_vec[de_rs2]
                  && !((cnt_arr[de_rs2] == CNT_W'(1)) && ld_done && (ld_done_rd == de_rs2));
        sat_haz = de_is_load && (de_rd != REG_ZERO) && max_vec[de_rd]
                  && !((ld_done && (ld_done_rd == de_rd)) || (kill && (kill_rd == de_rd)));
    end

    assign de_stall = de_valid && (rs1_haz || rs2_haz || sat_haz);
    assign de_fire  = de_valid && !de_stall;

`ifdef LOAD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] sat_stalls_q, sat_stalls_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        sat_stalls_d   = sat_stalls_q;
        if (de_valid && de_stall) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (de_valid && sat_haz && !rs1_haz && !rs2_haz) begin
            sat_stalls_d = sat_stalls_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            sat_stalls_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            sat_stalls_q   <= sat_stalls_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign sat_stalls   = sat_stalls_q;
`endif

endmodule

// File: tb/tb_load_scoreboard.sv
// tb/tb_load_scoreboard.sv - directed self-checking bench for load_scoreboard
module tb_load_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       de_valid, de_is_load;
    logic [4:0] de_rd, de_rs1, de_rs2;
    logic       de_rs1_used, de_rs2_used;
    logic       ld_done;
    logic [4:0] ld_done_rd;
    logic       kill;
    logic [4:0] kill_rd;
    logic       de_stall, de_fire;
`ifdef LOAD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] sat_stalls;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_scoreboard #(.CNT_W(2), .NREGS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .de_valid    (de_valid),
        .de_is_load  (de_is_load),
        .de_rd       (de_rd),
        .de_rs1      (de_rs1),
        .de_rs2      (de_rs2),
        .de_rs1_used (de_rs1_used),
        .de_rs2_used (de_rs2_used),
        .ld_done     (ld_done),
        .ld_done_rd  (ld_done_rd),
        .kill        (kill),
        .kill_rd     (kill_rd),
        .de_stall    (de_stall),
        .de_fire     (de_fire)
`ifdef LOAD_SCOREBOARD_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .sat_stalls  (sat_stalls)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        de_valid = 0; de_is_load = 0; de_rd = 0; de_rs1 = 0; de_rs2 = 0;
        de_rs1_used = 0; de_rs2_used = 0;
        ld_done = 0; ld_done_rd = 0; kill = 0; kill_rd = 0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] rd);
        idle();
        de_valid = 1; de_is_load = 1; de_rd = rd;
    endtask

    task automatic reader(input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        idle();
        de_valid = 1; de_rs1 = rs1; de_rs1_used = u1; de_rs2 = rs2; de_rs2_used = u2;
    endtask

    task automatic done(input logic [4:0] rd);
        ld_done = 1; ld_done_rd = rd;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    initial begin
        idle();
        do_reset();

        // Reset state: reader of x5 is free.
        reader(5, 1, 0, 0); #1;
        check("rst_stall", de_stall, 0);
        check("rst_fire", de_fire, 1);

        // Load x5, dependent stalls until ld_done rd=5 in the same cycle.
        load(5); #1;
        check("ld5_fire", de_fire, 1);
        cycle();
        reader(5, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1; check("x5_stall", de_stall, 1);
            check("x5_nofire", de_fire, 0);
            cycle();
        end
        done(5); #1;
        check("x5_release", de_stall, 0);
        check("x5_rel_fire", de_fire, 1);
        cycle();
        reader(5, 1, 0, 0); #1;
        check("x5_clear", de_stall, 0);
        cycle();

        // Load x0 then read x0: never tracked.
        load(0); #1;
        check("ld0_fire", de_fire, 1);
        cycle();
        reader(0, 1, 0, 1); #1;
        check("x0_read", de_stall, 0);
        cycle();

        // Three loads to x7, fourth saturates until ld_done rd=7.
        for (int i = 0; i < 3; i++) begin
            load(7); #1;
            check("ld7_fire", de_fire, 1);
            cycle();
        end
        load(7); #1;
        check("ld7_sat", de_stall, 1);
        cycle();
        load(7); done(7); #1;
        check("ld7_sat_rel", de_fire, 1);
        cycle();
        // Count is 3 again: another load still saturates.
        load(7); #1;
        check("ld7_sat_again", de_stall, 1);
        // Two outstanding: a completing one does not release a reader.
        idle(); done(7); cycle();
        reader(7, 1, 0, 0); done(7); #1;
        check("x7_two_left", de_stall, 1);
        cycle();
        reader(7, 1, 0, 0); done(7); #1;
        check("x7_last", de_stall, 0);
        cycle();
        reader(7, 1, 0, 0); #1;
        check("x7_clear", de_stall, 0);
        cycle();

        // Kill and issue to x3 in the same cycle keep count at 1.
        load(3); cycle();
        load(3); kill = 1; kill_rd = 3; #1;
        check("ld3_kill_fire", de_fire, 1);
        cycle();
        reader(0, 0, 3, 1); #1;
        check("x3_stall", de_stall, 1);
        cycle();
        reader(0, 0, 3, 1); done(3); #1;
        check("x3_release", de_stall, 0);
        cycle();
        reader(0, 0, 3, 1); #1;
        check("x3_clear", de_stall, 0);
        cycle();

        // Source-used gating on x9.
        load(9); cycle();
        reader(9, 0, 9, 0); #1;
        check("x9_unused", de_stall, 0);
        reader(0, 0, 9, 1); #1;
        check("x9_rs2_used", de_stall, 1);
        de_valid = 0; #1;
        check("x9_novalid", de_stall, 0);
        check("x9_novalid_fire", de_fire, 0);
        idle(); done(9); cycle();

        // Decrement of an empty counter holds at zero.
        idle(); done(12); cycle();
        load(12); #1;
        check("x12_no_wrap", de_fire, 1);
        cycle();
        reader(12, 1, 0, 0); #1;
        check("x12_stall", de_stall, 1);
        idle(); done(12); cycle();

        // Mid-operation reset discards tracking.
        load(6); cycle();
        reader(6, 1, 0, 0); #1;
        check("x6_stall", de_stall, 1);
        do_reset();
        reader(6, 1, 0, 0); #1;
        check("x6_after_rst", de_stall, 0);
        cycle();

`ifdef LOAD_SCOREBOARD_STATS_EN
        do_reset();
        load(10); cycle();
        reader(10, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        idle(); #1;
        check("stall_cycles", stall_cycles, 4);
        check("sat_none", {16'd0, sat_stalls}, 0);
        do_reset(); #1;
        check("stall_cycles_rst", stall_cycles, 0);
`endif

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
